pmem_responder: RTL and testbench

- Memory-side responder for the core's physical-memory read/write interface. It is the target that serves the load/store requests the core issues.
- Holds a DEPTH-word, 64-bit-wide storage array mapped at BASE_ADDR.
- Uses a valid/ready request channel and a valid/ready response channel.
- Access latency is programmable, so the core's memory stage can be exercised against non-zero-latency memory before real SRAM/AXI is integrated.

---
 rtl/pmem_responder.sv | 141 ++++++++++++++
 tb/tb_pmem_responder.sv | 377 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pmem_responder.sv
// Physical-memory responder: DEPTH x 64-bit storage at BASE_ADDR served over
// valid/ready request and response channels with a fixed, programmable access latency.
module pmem_responder #(
  parameter logic [63:0] BASE_ADDR  = 64'h0000_0000_8000_0000,
  parameter int          DEPTH_LOG2 = 10,
  parameter int          LATENCY    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wen,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  input  logic [7:0]  req_wmask,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [63:0] resp_rdata,
  output logic        resp_err
);

  localparam int          DEPTH    = 1 << DEPTH_LOG2;
  localparam logic [63:0] SPAN     = 64'(DEPTH) << 3;
  localparam logic [63:0] LIMIT    = BASE_ADDR + SPAN;
  localparam logic [3:0]  CNT_LOAD = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state_reg, state_next;
  logic [3:0]  cnt_reg, cnt_next;

  logic        wen_reg;
  logic [63:0] addr_reg;
  logic [63:0] wdata_reg;
  logic [7:0]  wmask_reg;
  logic [63:0] rdata_reg;
  logic        err_reg;

  logic                  accept;
  logic                  access;
  logic                  resp_done;
  logic                  in_range;
  logic                  mem_we;
  logic [DEPTH_LOG2-1:0] index;
  logic [63:0]           mem_rd;

  assign accept    = req_valid && (state_reg == IDLE);
  assign access    = (state_reg == BUSY) && (cnt_reg == 4'd0);
  assign resp_done = (state_reg == RESP) && resp_ready;

  // Full-address compares make the low three bits irrelevant because BASE_ADDR is word aligned.
  assign in_range = (addr_reg >= BASE_ADDR) && (addr_reg < LIMIT);
  assign index    = addr_reg[DEPTH_LOG2+2:3] - BASE_ADDR[DEPTH_LOG2+2:3];
  assign mem_we   = access && in_range && wen_reg;

  // One byte-wide array per lane so each lane maps onto a byte-write-enable RAM column.
  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_lane
      logic [7:0] lane_mem [DEPTH];

      always_ff @(posedge clk) begin
        if (mem_we && wmask_reg[gi]) begin
          lane_mem[index] <= wdata_reg[8*gi +: 8];
        end
      end

      assign mem_rd[8*gi +: 8] = lane_mem[index];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      cnt_reg   <= 4'd0;
      wen_reg   <= 1'b0;
      addr_reg  <= 64'd0;
      wdata_reg <= 64'd0;
      wmask_reg <= 8'd0;
      rdata_reg <= 64'd0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      if (accept) begin
        wen_reg   <= req_wen;
        addr_reg  <= req_addr;
        wdata_reg <= req_wdata;
        wmask_reg <= req_wmask;
      end
      // Response payload is captured once at the access edge and held through RESP.
      if (access) begin
        rdata_reg <= (in_range && !wen_reg) ? mem_rd : 64'd0;
        err_reg   <= !in_range;
      end else if (resp_done) begin
        rdata_reg <= 64'd0;
        err_reg   <= 1'b0;
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          state_next = BUSY;
          cnt_next   = CNT_LOAD;
        end
      end
      BUSY: begin
        if (cnt_reg == 4'd0) begin
          state_next = RESP;
        end else begin
          cnt_next = cnt_reg - 4'd1;
        end
      end
      RESP: begin
        if (resp_ready) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = 4'd0;
      end
    endcase
  end

  always_comb begin
    req_ready  = (state_reg == IDLE);
    resp_valid = (state_reg == RESP);
    resp_rdata = rdata_reg;
    resp_err   = err_reg;
  end

endmodule

// File: tb/tb_pmem_responder.sv
// Scoreboard bench for pmem_responder: a reference memory model predicts each
// response when the request is issued; responses are popped and compared on arrival.
module tb_pmem_responder;

  localparam logic [63:0] BASE = 64'h0000_0000_8000_0000;
  localparam int          LAT  = 2;
  localparam int          WORDS = 1024;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_wen;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic [7:0]  req_wmask;
  logic        resp_valid;
  logic        resp_ready;
  logic [63:0] resp_rdata;
  logic        resp_err;

  int tests_run = 0;
  int tests_failed = 0;

  logic [64:0] exp_q [$];
  logic [63:0] model_mem [WORDS];

  pmem_responder #(
    .BASE_ADDR (BASE),
    .DEPTH_LOG2(10),
    .LATENCY   (LAT)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_wen   (req_wen),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_wmask (req_wmask),
    .resp_valid(resp_valid),
    .resp_ready(resp_ready),
    .resp_rdata(resp_rdata),
    .resp_err  (resp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  // Drive one request, return 1 ns after the accepting edge, and push the predicted response.
  task automatic issue(input logic wen, input logic [63:0] addr, input logic [63:0] wdata,
                       input logic [7:0] wmask);
    logic [63:0] exp_rd;
    logic        exp_err;
    int          idx;
    @(negedge clk);
    for (int i = 0; i < 50 && !req_ready; i++) @(negedge clk);
    if (!req_ready) begin
      tests_run++;
      tests_failed++;
      $display("FAIL issue_ready: req_ready=%b, required 1 within 50 cycles", req_ready);
    end
    req_valid = 1'b1;
    req_wen   = wen;
    req_addr  = addr;
    req_wdata = wdata;
    req_wmask = wmask;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_wen   = 1'($urandom_range(0, 1));
    req_addr  = {$urandom, $urandom};
    req_wdata = {$urandom, $urandom};
    req_wmask = 8'($urandom);
    if (addr >= BASE && addr < BASE + 64'(WORDS * 8)) begin
      idx = int'((addr - BASE) >> 3);
      exp_err = 1'b0;
      if (wen) begin
        exp_rd = 64'd0;
        for (int b = 0; b < 8; b++) begin
          if (wmask[b]) model_mem[idx][8*b +: 8] = wdata[8*b +: 8];
        end
      end else begin
        exp_rd = model_mem[idx];
      end
    end else begin
      exp_rd  = 64'd0;
      exp_err = 1'b1;
    end
    exp_q.push_back({exp_err, exp_rd});
  endtask

  // Wait (bounded) for resp_valid; lat counts edges after acceptance, 0 on timeout.
  task automatic wait_resp(output int lat, output logic [63:0] rd, output logic err);
    lat = 0;
    rd  = 64'd0;
    err = 1'b0;
    for (int i = 1; i <= 50; i++) begin
      @(posedge clk);
      #1;
      if (resp_valid) begin
        lat = i;
        rd  = resp_rdata;
        err = resp_err;
        break;
      end
    end
  endtask

  task automatic handshake();
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    resp_ready = 1'b0;
  endtask

  task automatic do_txn(input string name, input logic wen, input logic [63:0] addr,
                        input logic [63:0] wdata, input logic [7:0] wmask,
                        output int lat, output logic [63:0] rd, output logic err);
    issue(wen, addr, wdata, wmask);
    wait_resp(lat, rd, err);
    handshake();
    $display("[TB] txn %s wen=%b addr=%h mask=%h lat=%0d rdata=%h err=%b",
             name, wen, addr, wmask, lat, rd, err);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    tests_run++;
    if ({req_ready, resp_valid, resp_rdata, resp_err} !== {1'b1, 1'b0, 64'd0, 1'b0}) begin
      tests_failed++;
      $display("FAIL reset_hold: ready=%b valid=%b rdata=%h err=%b, required 1 0 0 0",
               req_ready, resp_valid, resp_rdata, resp_err);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    tests_run++;
    if ({req_ready, resp_valid, resp_rdata, resp_err} !== {1'b1, 1'b0, 64'd0, 1'b0}) begin
      tests_failed++;
      $display("FAIL reset_idle: ready=%b valid=%b rdata=%h err=%b, required 1 0 0 0",
               req_ready, resp_valid, resp_rdata, resp_err);
    end
  endtask

  task automatic test_write_read();
    int lat; logic [63:0] rd; logic err; logic [64:0] e;
    do_txn("full_write", 1'b1, 64'h8000_0010, 64'h1122_3344_5566_7788, 8'hFF, lat, rd, err);
    e = exp_q.pop_front();
    tests_run++;
    if (lat != LAT || rd !== e[63:0] || err !== e[64]) begin
      tests_failed++;
      $display("FAIL full_write: lat=%0d rdata=%h err=%b, required lat=%0d rdata=%h err=%b",
               lat, rd, err, LAT, e[63:0], e[64]);
    end
    do_txn("read_back", 1'b0, 64'h8000_0010, 64'd0, 8'h00, lat, rd, err);
    e = exp_q.pop_front();
    tests_run++;
    if (lat != LAT || rd !== e[63:0] || err !== e[64]) begin
      tests_failed++;
      $display("FAIL read_back: lat=%0d rdata=%h err=%b, required lat=%0d rdata=%h err=%b",
               lat, rd, err, LAT, e[63:0], e[64]);
    end
  endtask

  task automatic test_partial_write();
    int lat; logic [63:0] rd; logic err; logic [64:0] e;
    do_txn("partial_write", 1'b1, 64'h8000_0010, 64'h8765_4321_1234_5678, 8'h03, lat, rd, err);
    e = exp_q.pop_front();
    tests_run++;
    if (lat != LAT || rd !== e[63:0] || err !== e[64]) begin
      tests_failed++;
      $display("FAIL partial_write: lat=%0d rdata=%h err=%b, required rdata=%h err=%b",
               lat, rd, err, e[63:0], e[64]);
    end
    do_txn("partial_read", 1'b0, 64'h8000_0010, 64'd0, 8'h00, lat, rd, err);
    e = exp_q.pop_front();
    tests_run++;
    if (lat != LAT || rd !== e[63:0] || err !== e[64]) begin
      tests_failed++;
      $display("FAIL partial_read: lat=%0d rdata=%h err=%b, required rdata=%h err=%b",
               lat, rd, err, e[63:0], e[64]);
    end
    do_txn("zero_mask", 1'b1, 64'h8000_0010, 64'hFFFF_FFFF_FFFF_FFFF, 8'h00, lat, rd, err);
    e = exp_q.pop_front();
    do_txn("zero_mask_rd", 1'b0, 64'h8000_0017, 64'd0, 8'h00, lat, rd, err);
    e = exp_q.pop_front();
    tests_run++;
    if (rd !== e[63:0] || err !== e[64]) begin
      tests_failed++;
      $display("FAIL zero_mask_read: rdata=%h err=%b, required rdata=%h err=%b",
               rd, err, e[63:0], e[64]);
    end
  endtask

  task automatic test_out_of_range();
    int lat; logic [63:0] rd; logic err; logic [64:0] e;
    do_txn("word0_init", 1'b1, 64'h8000_0000, 64'h0BAD_F00D_CAFE_BABE, 8'hFF, lat, rd, err);
    e = exp_q.pop_front();
    do_txn("oor_read_low", 1'b0, 64'h7FFF_FFF8, 64'd0, 8'h00, lat, rd, err);
    e = exp_q.pop_front();
    tests_run++;
    if (lat != LAT || rd !== e[63:0] || err !== e[64]) begin
      tests_failed++;
      $display("FAIL oor_read_low: rdata=%h err=%b, required rdata=%h err=%b",
               rd, err, e[63:0], e[64]);
    end
    do_txn("oor_write_high", 1'b1, 64'h8000_2000, 64'hDEAD_BEEF_DEAD_BEEF, 8'hFF, lat, rd, err);
    e = exp_q.pop_front();
    tests_run++;
    if (lat != LAT || rd !== e[63:0] || err !== e[64]) begin
      tests_failed++;
      $display("FAIL oor_write_high: rdata=%h err=%b, required rdata=%h err=%b",
               rd, err, e[63:0], e[64]);
    end
    do_txn("word0_check", 1'b0, 64'h8000_0000, 64'd0, 8'h00, lat, rd, err);
    e = exp_q.pop_front();
    tests_run++;
    if (rd !== e[63:0] || err !== e[64]) begin
      tests_failed++;
      $display("FAIL word0_check: rdata=%h err=%b, required rdata=%h err=%b",
               rd, err, e[63:0], e[64]);
    end
  endtask

  task automatic test_stall();
    int lat; logic [63:0] rd; logic err; logic [64:0] e;
    issue(1'b0, 64'h8000_0010, 64'd0, 8'h00);
    wait_resp(lat, rd, err);
    e = exp_q.pop_front();
    $display("[TB] txn stall_read lat=%0d rdata=%h err=%b", lat, rd, err);
    tests_run++;
    if (lat != LAT || rd !== e[63:0] || err !== e[64]) begin
      tests_failed++;
      $display("FAIL stall_first: lat=%0d rdata=%h err=%b, required lat=%0d rdata=%h",
               lat, rd, err, LAT, e[63:0]);
    end
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      tests_run++;
      if (resp_valid !== 1'b1 || resp_rdata !== e[63:0] || resp_err !== e[64] || req_ready !== 1'b0) begin
        tests_failed++;
        $display("FAIL stall_hold[%0d]: valid=%b rdata=%h ready=%b, required valid=1 rdata=%h ready=0",
                 c, resp_valid, resp_rdata, req_ready, e[63:0]);
      end
    end
    handshake();
    tests_run++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL stall_release: ready=%b valid=%b, required ready=1 valid=0", req_ready, resp_valid);
    end
  endtask

  task automatic test_reset_busy();
    int lat; logic [63:0] rd; logic err; logic [64:0] e;
    logic [63:0] saved;
    do_txn("pre_write", 1'b1, 64'h8000_0020, 64'hAAAA_5555_AAAA_5555, 8'hFF, lat, rd, err);
    e = exp_q.pop_front();
    saved = model_mem[4];
    issue(1'b1, 64'h8000_0020, 64'h1234_1234_1234_1234, 8'hFF);
    void'(exp_q.pop_front());
    model_mem[4] = saved;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    $display("[TB] txn busy_abort reset applied during BUSY");
    tests_run++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL busy_abort_idle: ready=%b valid=%b, required ready=1 valid=0", req_ready, resp_valid);
    end
    repeat (3) @(negedge clk);
    tests_run++;
    if (resp_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL busy_abort_noresp: valid=%b, required 0", resp_valid);
    end
    do_txn("busy_abort_rd", 1'b0, 64'h8000_0020, 64'd0, 8'h00, lat, rd, err);
    e = exp_q.pop_front();
    tests_run++;
    if (rd !== e[63:0] || err !== e[64]) begin
      tests_failed++;
      $display("FAIL busy_abort_read: rdata=%h err=%b, required rdata=%h err=%b",
               rd, err, e[63:0], e[64]);
    end
  endtask

  task automatic test_reset_resp();
    int lat; logic [63:0] rd; logic err; logic [64:0] e;
    for (int k = 0; k < 2; k++) begin
      if (k == 0) issue(1'b1, 64'h8000_0028, 64'hC0FF_EE00_1357_9BDF, 8'hFF);
      else        issue(1'b0, 64'h8000_0028, 64'd0, 8'h00);
      wait_resp(lat, rd, err);
      void'(exp_q.pop_front());
      #3;
      rst_n = 1'b0;
      #1;
      $display("[TB] txn resp_reset k=%0d lat=%0d rdata=%h", k, lat, rd);
      tests_run++;
      if ({req_ready, resp_valid, resp_rdata, resp_err} !== {1'b1, 1'b0, 64'd0, 1'b0}) begin
        tests_failed++;
        $display("FAIL async_reset[%0d]: ready=%b valid=%b rdata=%h err=%b, required 1 0 0 0",
                 k, req_ready, resp_valid, resp_rdata, resp_err);
      end
      @(negedge clk);
      rst_n = 1'b1;
    end
    do_txn("committed_rd", 1'b0, 64'h8000_0028, 64'd0, 8'h00, lat, rd, err);
    e = exp_q.pop_front();
    tests_run++;
    if (rd !== e[63:0] || err !== e[64]) begin
      tests_failed++;
      $display("FAIL committed_write: rdata=%h err=%b, required rdata=%h err=%b",
               rd, err, e[63:0], e[64]);
    end
  endtask

  task automatic test_back_to_back();
    int lat; logic [63:0] rd; logic err; logic [64:0] e;
    logic        wen;
    logic [63:0] addr;
    logic [7:0]  mask;
    for (int n = 0; n < 24; n++) begin
      if (n < 8) begin
        wen  = 1'b1;
        addr = BASE + 64'(64 + n * 8);
        mask = 8'hFF;
      end else begin
        wen  = 1'($urandom_range(0, 1));
        addr = BASE + 64'(64 + $urandom_range(0, 7) * 8 + $urandom_range(0, 7));
        mask = 8'($urandom);
      end
      resp_ready = 1'b1;
      issue(wen, addr, {$urandom, $urandom}, mask);
      wait_resp(lat, rd, err);
      handshake();
      e = exp_q.pop_front();
      $display("[TB] txn b2b[%0d] wen=%b addr=%h mask=%h lat=%0d rdata=%h err=%b",
               n, wen, addr, mask, lat, rd, err);
      tests_run++;
      if (lat != LAT || rd !== e[63:0] || err !== e[64]) begin
        tests_failed++;
        $display("FAIL b2b[%0d]: lat=%0d rdata=%h err=%b, required lat=%0d rdata=%h err=%b",
                 n, lat, rd, err, LAT, e[63:0], e[64]);
      end
    end
  endtask

  initial begin
    rst_n      = 1'b0;
    req_valid  = 1'b0;
    req_wen    = 1'b0;
    req_addr   = 64'd0;
    req_wdata  = 64'd0;
    req_wmask  = 8'd0;
    resp_ready = 1'b0;
    test_reset();
    test_write_read();
    test_partial_write();
    test_out_of_range();
    test_stall();
    test_reset_busy();
    test_reset_resp();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
